// File: rtl/uart_rx_poll_if.sv
// CPU-side I/O bus of the UART receiver: read strobes in, FIFO head/status/irq out.
interface uart_rx_poll_if;
    logic       clk0;
    logic       rd_data;
    logic       rd_stat;
    logic [7:0] rx_data;
    logic [7:0] rx_status;
    logic       rx_irq;

    modport master (
        output clk0, rd_data, rd_stat,
        input  rx_data, rx_status, rx_irq
    );

    modport slave (
        input  clk0, rd_data, rd_stat,
        output rx_data, rx_status, rx_irq
    );
endinterface

// File: rtl/uart_rx_poll.sv
// 8N1 UART receiver with a polled receive FIFO for the z80mini I/O read mux.
// Optional interrupt output: define UART_RX_IRQ_EN to make rx_irq follow READY.
module uart_rx_poll #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic          CLK50MHz,
    input  logic          nRESET,
    input  logic          rxd,
    uart_rx_poll_if.slave bus
);

    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW    = $clog2(DIV);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [CW-1:0]         DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0]         HALF_M1  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]         CNT_DEC  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  rxs_q, rxs_d;
    logic                  rxs_prev_q, rxs_prev_d;
    logic                  arm_q, arm_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  rd_data_s_q, rd_data_s_d;
    logic                  rd_stat_s_q, rd_stat_s_d;
    logic                  pop_q, pop_d;
    logic                  clr_q, clr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  framing_q, framing_d;
    logic [7:0]            mem_q [DEPTH];

    logic push, frame_err, push_ok, pop_ok, full;

    always_comb begin
        sync1_d    = rxd;
        rxs_d      = sync1_q;
        rxs_prev_d = rxs_q;
        arm_d      = arm_q | rxs_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        push       = 1'b0;
        frame_err  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm_q && rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    // A start bit that has gone high again by its centre is a glitch.
                    if (!rxs_q) begin
                        state_d = S_DATA;
                        cnt_d   = DIV_M1;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_DEC;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rxs_q;
                    cnt_d          = DIV_M1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - CNT_DEC;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    state_d   = S_IDLE;
                    push      = rxs_q;
                    frame_err = !rxs_q;
                end else begin
                    cnt_d = cnt_q - CNT_DEC;
                end
            end
        endcase

        // Read strobes are only looked at on CPU clock-phase cycles; act on the end of a read.
        rd_data_s_d = bus.clk0 ? bus.rd_data : rd_data_s_q;
        rd_stat_s_d = bus.clk0 ? bus.rd_stat : rd_stat_s_q;
        pop_d       = bus.clk0 & rd_data_s_q & ~bus.rd_data;
        clr_d       = bus.clk0 & rd_stat_s_q & ~bus.rd_stat;

        full    = (count_q == FULL_CNT);
        pop_ok  = pop_q & (count_q != '0);
        push_ok = push & (~full | pop_ok);

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        overrun_d = (overrun_q & ~clr_q) | (push & ~push_ok);
        framing_d = (framing_q & ~clr_q) | frame_err;
    end

    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            rxs_q       <= 1'b0;
            rxs_prev_q  <= 1'b0;
            arm_q       <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            rd_data_s_q <= 1'b0;
            rd_stat_s_q <= 1'b0;
            pop_q       <= 1'b0;
            clr_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            framing_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            rxs_prev_q  <= rxs_prev_d;
            arm_q       <= arm_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rd_data_s_q <= rd_data_s_d;
            rd_stat_s_q <= rd_stat_s_d;
            pop_q       <= pop_d;
            clr_q       <= clr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            framing_q   <= framing_d;
        end
    end

    always_ff @(posedge CLK50MHz) begin
        if (nRESET && push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign bus.rx_data   = (count_q == '0) ? 8'hFF : mem_q[rd_ptr_q];
    assign bus.rx_status = {4'(count_q), full, framing_q, overrun_q, (count_q != '0)};

`ifdef UART_RX_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = (count_q != '0);
    end

    always_ff @(posedge CLK50MHz) begin
        if (!nRESET) irq_q <= 1'b0;
        else         irq_q <= irq_d;
    end

    assign bus.rx_irq = irq_q;
`else
    assign bus.rx_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_poll.sv
// Scoreboard bench for uart_rx_poll: directed frames, expected status/data queued, checked by a monitor.
module tb_uart_rx_poll;

    localparam int DIV = 434;
`ifdef UART_RX_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] s;
        logic [7:0] d;
        logic       irq;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic nreset;
    logic rxd;
    logic probe;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    uart_rx_poll_if bus ();

    uart_rx_poll dut (
        .CLK50MHz (clk),
        .nRESET   (nreset),
        .rxd      (rxd),
        .bus      (bus)
    );

    always #10 clk = ~clk;

    // Monitor: compares the DUT outputs against the queued expectation on each probe.
    always @(negedge clk) begin
        if (probe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: probe with no expectation queued, got status=%02h", bus.rx_status);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (bus.rx_status !== e.s) begin
                    errors++;
                    $display("FAIL %s status: got %02h want %02h", e.name, bus.rx_status, e.s);
                end
                checks++;
                if (bus.rx_data !== e.d) begin
                    errors++;
                    $display("FAIL %s data: got %02h want %02h", e.name, bus.rx_data, e.d);
                end
                checks++;
                if (bus.rx_irq !== e.irq) begin
                    errors++;
                    $display("FAIL %s irq: got %0b want %0b", e.name, bus.rx_irq, e.irq);
                end
                $display("check %s: status=%02h data=%02h irq=%0b", e.name, bus.rx_status, bus.rx_data, bus.rx_irq);
            end
        end
    end

    function automatic logic [7:0] st(input int c, input bit ovr, input bit frm);
        st = {4'(c), (c == 8), frm, ovr, (c != 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [7:0] s, input logic [7:0] d, input string name);
        exp_t e;
        e.s    = s;
        e.d    = d;
        e.irq  = IRQ_ON ? s[0] : 1'b0;
        e.name = name;
        exp_q.push_back(e);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        tick();
        rxd = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) tick();
        end
        rxd = stop_bit;
        repeat (DIV) tick();
        rxd = 1'b1;
        repeat (20) tick();
    endtask

    task automatic cpu_read_data();
        tick();
        bus.rd_data = 1'b1; bus.clk0 = 1'b1;
        tick();
        bus.clk0 = 1'b0;
        tick();
        bus.rd_data = 1'b0; bus.clk0 = 1'b1;
        tick();
        bus.clk0 = 1'b0;
        repeat (3) tick();
    endtask

    task automatic cpu_read_stat();
        tick();
        bus.rd_stat = 1'b1; bus.clk0 = 1'b1;
        tick();
        bus.clk0 = 1'b0;
        tick();
        bus.rd_stat = 1'b0; bus.clk0 = 1'b1;
        tick();
        bus.clk0 = 1'b0;
        repeat (3) tick();
    endtask

    logic [7:0] pop_exp [8];

    initial begin
        probe       = 1'b0;
        nreset      = 1'b0;
        rxd         = 1'b1;
        bus.clk0    = 1'b0;
        bus.rd_data = 1'b0;
        bus.rd_stat = 1'b0;
        repeat (4) tick();
        nreset = 1'b1;
        repeat (10) tick();
        expect_out(8'h00, 8'hFF, "reset");

        send_byte(8'hA5, 1'b1);
        expect_out(8'h11, 8'hA5, "single_a5");
        cpu_read_data();
        expect_out(8'h00, 8'hFF, "single_popped");

        tick();
        rxd = 1'b0;
        repeat (100) tick();
        rxd = 1'b1;
        repeat (500) tick();
        expect_out(8'h00, 8'hFF, "glitch");

        send_byte(8'h3C, 1'b0);
        expect_out(8'h04, 8'hFF, "framing");
        cpu_read_stat();
        expect_out(8'h00, 8'hFF, "framing_clr");

        for (int i = 0; i < 9; i++) send_byte(8'(i), 1'b1);
        expect_out(8'h8B, 8'h00, "overrun_full");
        cpu_read_stat();
        expect_out(8'h89, 8'h00, "overrun_clr");

        // Push of 0x09 lands at edge 4125 after the start edge; the pop is timed to the same edge.
        fork
            send_byte(8'h09, 1'b1);
            begin
                tick();
                tick();
                bus.rd_data = 1'b1; bus.clk0 = 1'b1;
                tick();
                bus.clk0 = 1'b0;
                repeat (4122) tick();
                bus.rd_data = 1'b0; bus.clk0 = 1'b1;
                tick();
                bus.clk0 = 1'b0;
            end
        join
        expect_out(8'h89, 8'h01, "simultaneous");

        pop_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09};
        for (int k = 0; k < 8; k++) begin
            expect_out(st(8 - k, 1'b0, 1'b0), pop_exp[k], $sformatf("pop%0d", k));
            cpu_read_data();
        end
        expect_out(8'h00, 8'hFF, "drained");

        send_byte(8'h55, 1'b1);
        expect_out(8'h11, 8'h55, "wrap_55");

        tick();
        rxd = 1'b0;
        repeat (1000) tick();
        nreset = 1'b0;
        repeat (3) tick();
        nreset = 1'b1;
        repeat (5) tick();
        expect_out(8'h00, 8'hFF, "reset_midframe");
        repeat (1995) tick();
        rxd = 1'b1;
        repeat (50) tick();
        expect_out(8'h00, 8'hFF, "low_line_ignored");
        send_byte(8'h7E, 1'b1);
        expect_out(8'h11, 8'h7E, "after_reset_7e");

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
